// File: rtl/regfile_access_arbiter.sv
// Two-requester front end (core datapath, debug/loader) for the register file port,
// with starvation-bounded debug access and an optional burst-read engine (RF_ARB_BURST_EN).
module regfile_access_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_we,
    input  logic                  d_burst,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [ADDR_WIDTH-1:0] d_len,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_busy,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  rf_write_en,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  in_burst;
    logic                  dbg_pend;
    logic                  dbg_gnt;
    logic                  core_gnt;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_data;

`ifdef RF_ARB_BURST_EN
    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] remaining;

    assign in_burst = (state == BURST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
        end else if (dbg_gnt) begin
            case (state)
                IDLE: begin
                    if (d_burst) begin
                        ptr       <= d_addr;
                        remaining <= d_len;
                        state     <= (d_len != '0) ? BURST : IDLE;
                    end
                end
                BURST: begin
                    ptr       <= ptr + ADDR_WIDTH'(1);
                    remaining <= remaining - ADDR_WIDTH'(1);
                    if (remaining == ADDR_WIDTH'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_burst_in;

    assign in_burst        = 1'b0;
    assign unused_burst_in = ^{d_burst, d_len};
`endif

    assign d_busy  = in_burst;
    assign c_ready = core_gnt;
    assign d_ready = dbg_gnt & ~in_burst;

    always_comb begin
        dbg_pend = in_burst | d_valid;
        dbg_gnt  = rst_n & dbg_pend & (~c_valid | (starve_cnt == LIMIT));
        core_gnt = rst_n & c_valid & ~dbg_gnt;

        dbg_addr = d_addr;
        dbg_data = d_wdata;
        dbg_we   = d_we;
`ifdef RF_ARB_BURST_EN
        // Burst beats read the next register and leave the data bus untouched.
        if (in_burst) begin
            dbg_addr = ptr + ADDR_WIDTH'(1);
            dbg_data = data_q;
            dbg_we   = 1'b0;
        end else if (d_burst) begin
            dbg_we   = 1'b0;
        end
`endif

        if (core_gnt) begin
            rf_address  = c_addr;
            rf_data     = c_wdata;
            rf_write_en = c_we;
        end else if (dbg_gnt) begin
            rf_address  = dbg_addr;
            rf_data     = dbg_data;
            rf_write_en = dbg_we;
        end else begin
            rf_address  = addr_q;
            rf_data     = data_q;
            rf_write_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            c_rvalid   <= 1'b0;
            c_rdata    <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
        end else begin
            c_rvalid <= core_gnt & ~c_we;
            if (core_gnt & ~c_we)
                c_rdata <= rf_rdata;
            d_rvalid <= dbg_gnt & ~dbg_we;
            if (dbg_gnt & ~dbg_we)
                d_rdata <= rf_rdata;

            if (core_gnt | dbg_gnt) begin
                addr_q <= rf_address;
                data_q <= rf_data;
            end

            if (dbg_gnt | ~dbg_pend)
                starve_cnt <= '0;
            else if (core_gnt && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Self-checking bench for regfile_access_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural model of the arbitration rules and register file.
module tb_regfile_access_arbiter;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int LIM = 3;
    localparam int N   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_valid = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_ready, c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          d_valid = 1'b0, d_we = 1'b0, d_burst = 1'b0;
    logic [AW-1:0] d_addr = '0, d_len = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready, d_rvalid, d_busy;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] rf_address;
    logic [DW-1:0] rf_data;
    logic          rf_write_en;
    logic [DW-1:0] rf_rdata;

    logic [DW-1:0] mem [N];

    always #5 clk = ~clk;

    // Register file environment: combinational read, write at the clock edge.
    assign rf_rdata = mem[rf_address];
    always @(posedge clk) if (rf_write_en) mem[rf_address] <= rf_data;

    regfile_access_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_burst(d_burst),
        .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_busy(d_busy),
        .rf_address(rf_address), .rf_data(rf_data), .rf_write_en(rf_write_en),
        .rf_rdata(rf_rdata)
    );

    int checks = 0;
    int errors = 0;

    int m_mem [N];
    int m_starve = 0, m_left = 0, m_ptr = 0, m_addr_hold = 0, m_data_hold = 0;
    bit e_crv = 0, e_drv = 0;
    int e_crd = 0, e_drd = 0;

    logic g_cready, g_dready, g_wen, g_drvalid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        c_valid = 0; c_we = 0; d_valid = 0; d_we = 0; d_burst = 0;
    endtask

    // One clock cycle: check grant/port outputs against the model, let the edge pass,
    // then check the registered responses.
    task automatic step();
        bit in_burst, dpend, cg, dg, we;
        int addr, wd;
        #1;
        in_burst = 0;
`ifdef RF_ARB_BURST_EN
        in_burst = (m_left > 0);
`endif
        dpend = in_burst || d_valid;
        dg    = rst_n && dpend && (!c_valid || m_starve == LIM);
        cg    = rst_n && c_valid && !dg;
        addr  = m_addr_hold;
        wd    = m_data_hold;
        we    = 0;
        if (cg) begin
            addr = c_addr; wd = c_wdata; we = c_we;
        end else if (dg) begin
            if (in_burst) begin
                addr = (m_ptr + 1) % N;
            end else begin
                addr = d_addr; wd = d_wdata; we = d_we;
`ifdef RF_ARB_BURST_EN
                if (d_burst) we = 0;
`endif
            end
        end

        chk("c_ready", c_ready, cg);
        chk("d_ready", d_ready, dg && !in_burst);
        chk("rf_write_en", rf_write_en, (cg || dg) && we);
        if (rst_n) chk("rf_address", rf_address, addr);
        if ((cg || dg) && we) chk("rf_data", rf_data, wd);
        g_cready = c_ready;
        g_dready = d_ready;
        g_wen    = rf_write_en;

        if (!rst_n) begin
            m_starve = 0; m_left = 0; m_addr_hold = 0; m_data_hold = 0;
            e_crv = 0; e_drv = 0; e_crd = 0; e_drd = 0;
        end else begin
            e_crv = cg && !we;
            e_drv = dg && !we;
            if (e_crv) e_crd = m_mem[addr];
            if (e_drv) e_drd = m_mem[addr];
            if ((cg || dg) && we) m_mem[addr] = wd;
            if (cg || dg) begin
                m_addr_hold = addr;
                m_data_hold = wd;
            end
`ifdef RF_ARB_BURST_EN
            if (dg && in_burst) begin
                m_ptr = (m_ptr + 1) % N;
                m_left--;
            end else if (dg && d_burst) begin
                m_ptr  = d_addr;
                m_left = d_len;
            end
`endif
            if (dg || !dpend) m_starve = 0;
            else if (cg && m_starve < LIM) m_starve++;
        end

        @(posedge clk);
        #1;
        chk("c_rvalid", c_rvalid, e_crv);
        chk("c_rdata", c_rdata, e_crd);
        chk("d_rvalid", d_rvalid, e_drv);
        chk("d_rdata", d_rdata, e_drd);
        chk("d_busy", d_busy, m_left > 0);
        g_drvalid = d_rvalid;
    endtask

    task automatic core_write(input int a, input int v);
        idle_inputs();
        c_valid = 1; c_we = 1; c_addr = AW'(a); c_wdata = DW'(v);
        step();
    endtask

    initial begin
        int grant_at, cnt;

        // Reset with every request asserted: grants must stay low.
        rst_n = 0;
        c_valid = 1; c_we = 1; d_valid = 1; d_we = 1;
        step();
        step();
        chk("reset_c_rvalid", c_rvalid, 0);
        chk("reset_rf_address", rf_address, 0);
        rst_n = 1;
        idle_inputs();
        step();

        for (int i = 0; i < N; i++) core_write(i, i);

        // Core write then read-back of the same register.
        core_write(3, 8'hA5);
        chk("tp_write_en", g_wen, 1);
        idle_inputs();
        c_valid = 1; c_we = 0; c_addr = 3;
        step();
        chk("tp_read_rvalid", c_rvalid, 1);
        chk("tp_read_rdata", c_rdata, 8'hA5);

        // Simultaneous core and debug reads: core first, debug next.
        core_write(1, 8'h11);
        core_write(2, 8'h22);
        idle_inputs();
        c_valid = 1; c_addr = 1; d_valid = 1; d_addr = 2;
        step();
        chk("both_c_ready", g_cready, 1);
        chk("both_d_ready", g_dready, 0);
        chk("both_c_rdata", c_rdata, 8'h11);
        c_valid = 0;
        step();
        chk("both_d_ready2", g_dready, 1);
        chk("both_d_rdata", d_rdata, 8'h22);

        // Starvation bound under continuous core traffic.
        idle_inputs();
        step();
        grant_at = -1;
        for (int i = 0; i < 8; i++) begin
            c_valid = 1; c_we = 0; c_addr = AW'(i);
            d_valid = (grant_at < 0); d_we = 0; d_addr = 4;
            step();
            if (g_dready && grant_at < 0) begin
                grant_at = i;
                chk("starve_c_ready", g_cready, 0);
            end
        end
        chk("starve_grant_cycle", grant_at, LIM);

`ifdef RF_ARB_BURST_EN
        // Wrapping burst over a file holding value == index.
        core_write(1, 1);
        idle_inputs();
        step();
        d_valid = 1; d_burst = 1; d_addr = 14; d_len = 3;
        step();
        chk("burst_beat0", d_rdata, 14);
        chk("burst_busy0", d_busy, 1);
        idle_inputs();
        step();
        chk("burst_beat1", d_rdata, 15);
        step();
        chk("burst_beat2", d_rdata, 0);
        step();
        chk("burst_beat3", d_rdata, 1);
        chk("burst_busy_end", d_busy, 0);

        // Reset during a 6-beat burst.
        d_valid = 1; d_burst = 1; d_addr = 0; d_len = 5;
        step();
        idle_inputs();
        step();
        rst_n = 0;
        step();
        chk("rst_burst_busy", d_busy, 0);
        chk("rst_burst_rvalid", d_rvalid, 0);
        rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            cnt += int'(g_drvalid);
        end
        chk("rst_burst_no_resp", cnt, 0);
`else
        // Burst request without the engine is a single read.
        idle_inputs();
        d_valid = 1; d_burst = 1; d_we = 0; d_addr = 5; d_len = 3;
        step();
        cnt = int'(g_drvalid);
        chk("single_rdata", d_rdata, 5);
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            step();
            cnt += int'(g_drvalid);
            chk("single_busy", d_busy, 0);
        end
        chk("single_resp_count", cnt, 1);
`endif

        // Randomized mixed traffic.
        for (int i = 0; i < 400; i++) begin
            c_valid = ($urandom_range(0, 3) != 0);
            c_we    = $urandom_range(0, 1);
            c_addr  = AW'($urandom_range(0, N - 1));
            c_wdata = DW'($urandom);
            d_valid = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1);
            d_burst = ($urandom_range(0, 7) == 0);
            d_addr  = AW'($urandom_range(0, N - 1));
            d_len   = AW'($urandom_range(0, 5));
            d_wdata = DW'($urandom);
            rst_n   = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1;
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_access_arbiter.md
# regfile_access_arbiter

Front-end arbiter for the microcontroller register file. It merges two requesters, the core datapath and the debug/loader port, into the single address/data/write-enable port of the register file. It returns read data one cycle after acceptance. It also provides a debug burst-read engine for dumping consecutive registers.

## Interface
Parameters:
- DATA_WIDTH, 8, register width; equals the register file data width.
- ADDR_WIDTH, 4, register address width; the file holds 2**ADDR_WIDTH entries.
- STARVE_LIMIT, 3, maximum number of consecutive core grants while debug is pending (range 1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- c_valid  in  1  core request valid.
- c_ready  out  1  core request accepted this cycle (combinational grant).
- c_we  in  1  1 = write, 0 = read.
- c_addr  in  ADDR_WIDTH  core register address.
- c_wdata  in  DATA_WIDTH  core write data.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_WIDTH  core read data.
- d_valid  in  1  debug request valid.
- d_ready  out  1  debug request accepted.
- d_we  in  1  debug write.
- d_burst  in  1  burst read request; d_we is ignored when d_burst=1.
- d_addr  in  ADDR_WIDTH  debug address or burst start address.
- d_len  in  ADDR_WIDTH  burst beat count minus 1.
- d_wdata  in  DATA_WIDTH  debug write data.
- d_rvalid  out  1  debug read data valid.
- d_rdata  out  DATA_WIDTH  debug read data.
- d_busy  out  1  burst in progress.
- rf_address  out  ADDR_WIDTH  to regfile i_address.
- rf_data  out  DATA_WIDTH  to regfile i_data.
- rf_write_en  out  1  to regfile i_write_en.
- rf_rdata  in  DATA_WIDTH  from regfile o_data (combinational read of rf_address).

## Operation
- FSM states:
  - IDLE: single accesses.
  - BURST: the engine issues reads.
- Pending sources:
  - Debug is pending when d_valid=1 in IDLE, or a beat remains in BURST.
  - Core is pending when c_valid=1.
- Grant rule, one access per cycle:
  - Core wins by default.
  - Debug wins when core is not pending, or when starve_cnt == STARVE_LIMIT.
- starve_cnt:
  - Increments when core is granted while debug is pending.
  - Clears when debug is granted or when debug is not pending.
  - Saturates at STARVE_LIMIT.
- The granted request drives rf_address and rf_data. rf_write_en = granted & we.
- With no grant: rf_write_en=0, and rf_address/rf_data hold their last driven values.
- c_ready = core granted. d_ready = debug granted in IDLE; d_ready is 0 in BURST.
- Reads:
  - rf_rdata is sampled at the accepting edge.
  - The corresponding rvalid pulses for 1 cycle and rdata holds its value until the next read response.
- Writes produce no response.
- Burst:
  - Accepting d_burst=1 with d_ready loads ptr=d_addr and remaining=d_len. That cycle is beat 0.
  - If d_len=0, the FSM stays in IDLE. Otherwise it goes to BURST.
  - Each subsequent debug grant in BURST reads ptr+1, wrapping modulo 2**ADDR_WIDTH, and decrements remaining.
  - The beat that brings remaining to 0 returns the FSM to IDLE.
  - d_busy = (state == BURST).
- Same-cycle write and read by different sources is impossible, since there is one grant per cycle.
- A write followed next cycle by a read of the same address returns the new value.

## Timing
- Reset values (while rst_n=0 at an edge):
  - state=IDLE, starve_cnt=0.
  - c_rvalid, d_rvalid, c_rdata, d_rdata = 0.
  - rf_address, rf_data = 0.
  - c_ready, d_ready, rf_write_en forced 0 combinationally while rst_n=0.
- Read latency: accept at edge N; rvalid=1 in cycle N+1.
- Write commits in the regfile at the accepting edge.
- Burst of L=d_len+1 beats with no core traffic: responses in L consecutive cycles starting 1 cycle after acceptance. d_busy falls in the cycle after the last beat is issued.
- Reset mid-burst: the FSM returns to IDLE immediately. The response of a beat already issued is still cleared by reset. No further beats are issued.
- Continuous core traffic: debug is granted at most STARVE_LIMIT+1 cycles after it becomes pending.

## Configuration
- RF_ARB_BURST_EN:
  - Defined: BURST state, ptr/remaining counters and d_busy logic are compiled in.
  - Undefined: d_burst and d_len are ignored, every debug request is a single access per d_we, and d_busy is tied to 0.

## Test plan
- Core write 0xA5 to r3, then core read r3 → rf_write_en=1 in cycle 0; c_rvalid=1 with c_rdata=0xA5 in cycle 2.
- Core and debug reads valid together (r1=0x11, r2=0x22) → core served first; debug served next cycle; d_rdata=0x22.
- Core valid every cycle with STARVE_LIMIT=3 and a debug read held valid → d_ready=1 exactly on the 4th cycle; c_ready=0 that cycle.
- Burst d_addr=14, d_len=3, file preloaded with value=index → d_rdata sequence 14, 15, 0, 1 on consecutive cycles; d_busy clears after the last beat.
- Reset asserted during the 2nd beat of a 6-beat burst → next cycle d_busy=0 and d_rvalid=0; no further responses after release.
- Build without RF_ARB_BURST_EN, d_burst=1 with d_we=0, addr 5 → exactly one d_rvalid; d_busy stays 0.
